// File: rtl/airi5c_wb_sequencer_pkg.sv
// Shared write-back control constants for the AIRI5C pipeline: data width,
// write-back source codes and load-type codes.
package airi5c_wb_sequencer_pkg;

  localparam int XPR_LEN = 32;

  // Write-back source select
  localparam int          WB_SRC_WIDTH = 2;
  localparam logic [1:0]  WB_SRC_ALU   = 2'd0;
  localparam logic [1:0]  WB_SRC_MEM   = 2'd1;
  localparam logic [1:0]  WB_SRC_CSR   = 2'd2;
  localparam logic [1:0]  WB_SRC_PCPI  = 2'd3;

  // Load types (funct3-style encoding)
  localparam int          MEM_TYPE_WIDTH = 3;
  localparam logic [2:0]  MT_B  = 3'd0;
  localparam logic [2:0]  MT_H  = 3'd1;
  localparam logic [2:0]  MT_W  = 3'd2;
  localparam logic [2:0]  MT_BU = 3'd4;
  localparam logic [2:0]  MT_HU = 3'd5;

endpackage

// File: rtl/airi5c_wb_sequencer_if.sv
// Write-back stage bundle: WB pipeline register contents, result sources,
// data-memory load response, and register-file write port.
interface airi5c_wb_sequencer_if;
  import airi5c_wb_sequencer_pkg::*;

  logic                      wb_valid_i;
  logic                      wb_we_i;
  logic [4:0]                wb_rd_i;
  logic [WB_SRC_WIDTH-1:0]   wb_src_i;
  logic [XPR_LEN-1:0]        alu_out_i;
  logic [XPR_LEN-1:0]        csr_rdata_i;
  logic [XPR_LEN-1:0]        pcpi_rd_i;
  logic [XPR_LEN-1:0]        pcpi_rd2_i;
  logic                      pcpi_use_rd64_i;
  logic [MEM_TYPE_WIDTH-1:0] dmem_type_i;
  logic [XPR_LEN-1:0]        dmem_rdata_i;
  logic                      dmem_ready_i;
  logic                      dmem_err_i;
  logic                      flush_i;
  logic                      stall_WB_o;
  logic                      rf_we_o;
  logic [4:0]                rf_waddr_o;
  logic [XPR_LEN-1:0]        rf_wdata_o;
  logic                      load_err_o;

  // Sequencer side
  modport slave (
    input  wb_valid_i, wb_we_i, wb_rd_i, wb_src_i, alu_out_i, csr_rdata_i,
           pcpi_rd_i, pcpi_rd2_i, pcpi_use_rd64_i, dmem_type_i, dmem_rdata_i,
           dmem_ready_i, dmem_err_i, flush_i,
    output stall_WB_o, rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o
  );

  // Pipeline / environment side
  modport master (
    output wb_valid_i, wb_we_i, wb_rd_i, wb_src_i, alu_out_i, csr_rdata_i,
           pcpi_rd_i, pcpi_rd2_i, pcpi_use_rd64_i, dmem_type_i, dmem_rdata_i,
           dmem_ready_i, dmem_err_i, flush_i,
    input  stall_WB_o, rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o
  );

endinterface

// File: rtl/airi5c_load_align.sv
// Load data alignment: shifts the raw memory word down by the byte offset
// and sign- or zero-extends according to the load type. Purely combinational.
module airi5c_load_align
  import airi5c_wb_sequencer_pkg::*;
(
  input  logic [1:0]                offset_i,
  input  logic [MEM_TYPE_WIDTH-1:0] type_i,
  input  logic [XPR_LEN-1:0]        rdata_i,
  output logic [XPR_LEN-1:0]        data_o
);

  logic [XPR_LEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Extend the addressed byte/halfword to full width
  always_comb begin
    // NOTE: every case arm assigns data_o and the default covers the rest, so no latch is inferred.
    case (type_i)
      MT_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      MT_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      MT_BU:   data_o = {24'd0, shifted[7:0]};
      MT_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/airi5c_wb_sequencer.sv
// AIRI5C write-back sequencer: owns the single register-file write port,
// selects the write-back source, waits for load responses and sequences
// 64-bit PCPI results over two cycles.
// Optional feature macro: AIRI5C_WB_RD64_EN (two-cycle 64-bit PCPI write-back).
module airi5c_wb_sequencer
  import airi5c_wb_sequencer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  airi5c_wb_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
`ifdef AIRI5C_WB_RD64_EN
  localparam logic [1:0] S_RD64_HI  = 2'd2;
`endif

  logic [1:0]         state_q, state_d;
  logic               drop_q, drop_d;
  logic               live;
  logic [XPR_LEN-1:0] load_data;
  logic               stall, we, err;
  logic [4:0]         waddr;
  logic [XPR_LEN-1:0] wdata;

  assign live = bus.wb_valid_i & bus.wb_we_i;

  airi5c_load_align u_load_align (
    .offset_i (bus.alu_out_i[1:0]),
    .type_i   (bus.dmem_type_i),
    .rdata_i  (bus.dmem_rdata_i),
    .data_o   (load_data)
  );

`ifndef AIRI5C_WB_RD64_EN
  // The high PCPI half is only meaningful when 64-bit write-back is built in.
  logic unused_rd64;
  assign unused_rd64 = bus.pcpi_use_rd64_i ^ (^bus.pcpi_rd2_i);
`endif

  // Next-state and write-port decode
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    stall   = 1'b0;
    we      = 1'b0;
    err     = 1'b0;
    waddr   = '0;
    wdata   = '0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (live && !bus.flush_i) begin
          waddr = bus.wb_rd_i;
          case (bus.wb_src_i)
            WB_SRC_MEM: begin
              if (bus.dmem_ready_i) begin
                err   = bus.dmem_err_i;
                we    = ~bus.dmem_err_i;
                wdata = load_data;
              end else begin
                stall   = 1'b1;
                state_d = S_MEM_WAIT;
              end
            end
            WB_SRC_CSR: begin
              we    = 1'b1;
              wdata = bus.csr_rdata_i;
            end
            WB_SRC_PCPI: begin
              we    = 1'b1;
              wdata = bus.pcpi_rd_i;
`ifdef AIRI5C_WB_RD64_EN
              if (bus.pcpi_use_rd64_i) begin
                stall   = 1'b1;
                state_d = S_RD64_HI;
              end
`endif
            end
            default: begin
              we    = 1'b1;
              wdata = bus.alu_out_i;
            end
          endcase
        end
      end

      S_MEM_WAIT: begin
        // A flushed load still has to swallow its bus response.
        if (bus.dmem_ready_i) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !bus.flush_i) begin
            waddr = bus.wb_rd_i;
            err   = bus.dmem_err_i;
            we    = ~bus.dmem_err_i;
            wdata = load_data;
          end
        end else begin
          stall = 1'b1;
          if (bus.flush_i) drop_d = 1'b1;
        end
      end

`ifdef AIRI5C_WB_RD64_EN
      S_RD64_HI: begin
        state_d = S_IDLE;
        if (!bus.flush_i) begin
          we    = 1'b1;
          waddr = bus.wb_rd_i + 5'd1;
          wdata = bus.pcpi_rd2_i;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held; writes to x0 never happen
  assign bus.stall_WB_o = rst_ni & stall;
  assign bus.rf_we_o    = rst_ni & we & (waddr != 5'd0);
  assign bus.rf_waddr_o = rst_ni ? waddr : '0;
  assign bus.rf_wdata_o = rst_ni ? wdata : '0;
  assign bus.load_err_o = rst_ni & err;

  // State and drop flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: async reset clears only the control state; the data path holds no registers to reset.
    if (!rst_ni) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_airi5c_wb_sequencer.sv
// Directed self-checking bench for airi5c_wb_sequencer.
// Honours AIRI5C_WB_RD64_EN for the 64-bit PCPI expectations.
module tb_airi5c_wb_sequencer;
  import airi5c_wb_sequencer_pkg::*;

  logic clk_i;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_bad = 0;

  airi5c_wb_sequencer_if bus ();

  airi5c_wb_sequencer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check stall/we/err, and address/data only when a write is expected
  task automatic expect_out(input string tag, input logic stall, input logic we,
                            input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic err);
    check({tag, ".stall"}, {31'd0, bus.stall_WB_o}, {31'd0, stall});
    check({tag, ".we"},    {31'd0, bus.rf_we_o},    {31'd0, we});
    check({tag, ".err"},   {31'd0, bus.load_err_o}, {31'd0, err});
    if (we) begin
      check({tag, ".waddr"}, {27'd0, bus.rf_waddr_o}, {27'd0, waddr});
      check({tag, ".wdata"}, bus.rf_wdata_o, wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    bus.wb_valid_i      = 1'b0;
    bus.wb_we_i         = 1'b0;
    bus.flush_i         = 1'b0;
    bus.dmem_ready_i    = 1'b0;
    bus.dmem_err_i      = 1'b0;
    bus.pcpi_use_rd64_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] src, input logic [4:0] rd);
    bus.wb_valid_i = 1'b1;
    bus.wb_we_i    = 1'b1;
    bus.wb_src_i   = src;
    bus.wb_rd_i    = rd;
  endtask

  initial begin
    rst_ni = 1'b0;
    quiet();
    bus.wb_rd_i      = '0;
    bus.wb_src_i     = WB_SRC_ALU;
    bus.alu_out_i    = '0;
    bus.csr_rdata_i  = '0;
    bus.pcpi_rd_i    = '0;
    bus.pcpi_rd2_i   = '0;
    bus.dmem_type_i  = MT_W;
    bus.dmem_rdata_i = '0;

    // Reset held with a live ALU write presented: everything quiet
    issue(WB_SRC_ALU, 5'd5);
    bus.alu_out_i = 32'h1234;
    #1;
    check("rst.stall", {31'd0, bus.stall_WB_o}, 32'd0);
    check("rst.we",    {31'd0, bus.rf_we_o},    32'd0);
    check("rst.err",   {31'd0, bus.load_err_o}, 32'd0);
    check("rst.waddr", {27'd0, bus.rf_waddr_o}, 32'd0);
    check("rst.wdata", bus.rf_wdata_o,          32'd0);
    tick();
    rst_ni = 1'b1;
    #1;

    // ALU write, same cycle
    expect_out("alu", 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
    tick();

    // CSR write
    issue(WB_SRC_CSR, 5'd7);
    bus.csr_rdata_i = 32'hDEAD_BEEF;
    #1;
    expect_out("csr", 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    tick();

    // Write to x0 suppressed
    issue(WB_SRC_ALU, 5'd0);
    #1;
    expect_out("x0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();

    // Load with we=0 is ignored: no stall even without ready
    issue(WB_SRC_MEM, 5'd9);
    bus.wb_we_i = 1'b0;
    #1;
    expect_out("ld_nowe", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();

    // Single-width PCPI
    issue(WB_SRC_PCPI, 5'd12);
    bus.pcpi_rd_i = 32'hCAFE_0001;
    #1;
    expect_out("pcpi32", 1'b0, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0);
    tick();

    // LB offset 3, ready after two wait cycles
    issue(WB_SRC_MEM, 5'd10);
    bus.dmem_type_i  = MT_B;
    bus.alu_out_i    = 32'h0000_1003;
    bus.dmem_rdata_i = 32'h80FF_FFFF;
    #1;
    expect_out("lb.w0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    expect_out("lb.w1", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    bus.dmem_ready_i = 1'b1;
    #1;
    expect_out("lb.rdy", 1'b0, 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0);
    tick();
    quiet();
    #1;
    expect_out("lb.idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // LBU, same stimulus
    issue(WB_SRC_MEM, 5'd11);
    bus.dmem_type_i = MT_BU;
    #1;
    expect_out("lbu.w0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    expect_out("lbu.w1", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    bus.dmem_ready_i = 1'b1;
    #1;
    expect_out("lbu.rdy", 1'b0, 1'b1, 5'd11, 32'h0000_0080, 1'b0);
    tick();

    // Immediate loads: LH offset 2, LHU offset 0, LW
    issue(WB_SRC_MEM, 5'd13);
    bus.dmem_ready_i = 1'b1;
    bus.dmem_type_i  = MT_H;
    bus.alu_out_i    = 32'h0000_0002;
    bus.dmem_rdata_i = 32'h8001_1234;
    #1;
    expect_out("lh", 1'b0, 1'b1, 5'd13, 32'hFFFF_8001, 1'b0);
    tick();
    bus.dmem_type_i  = MT_HU;
    bus.alu_out_i    = 32'h0000_0000;
    bus.dmem_rdata_i = 32'h1234_F00D;
    #1;
    expect_out("lhu", 1'b0, 1'b1, 5'd13, 32'h0000_F00D, 1'b0);
    tick();
    bus.dmem_type_i  = MT_W;
    bus.dmem_rdata_i = 32'h89AB_CDEF;
    #1;
    expect_out("lw", 1'b0, 1'b1, 5'd13, 32'h89AB_CDEF, 1'b0);
    tick();

    // Load error: no write, one-cycle pulse, back in IDLE
    bus.dmem_err_i = 1'b1;
    #1;
    expect_out("lerr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    quiet();
    #1;
    expect_out("lerr.after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Flush in MEM_WAIT, then error response is swallowed
    issue(WB_SRC_MEM, 5'd14);
    #1;
    expect_out("fl.w0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    bus.flush_i = 1'b1;
    #1;
    expect_out("fl.flush", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    bus.flush_i      = 1'b0;
    bus.dmem_ready_i = 1'b1;
    bus.dmem_err_i   = 1'b1;
    #1;
    expect_out("fl.rdy", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    quiet();
    issue(WB_SRC_ALU, 5'd3);
    bus.alu_out_i = 32'h0000_0033;
    #1;
    expect_out("fl.next", 1'b0, 1'b1, 5'd3, 32'h0000_0033, 1'b0);
    tick();

    // 64-bit PCPI with rd=31: high half wraps to x0
    quiet();
    issue(WB_SRC_PCPI, 5'd31);
    bus.pcpi_use_rd64_i = 1'b1;
    bus.pcpi_rd_i       = 32'h0000_0001;
    bus.pcpi_rd2_i      = 32'h0000_0002;
    #1;
`ifdef AIRI5C_WB_RD64_EN
    expect_out("rd64w.c0", 1'b1, 1'b1, 5'd31, 32'h0000_0001, 1'b0);
    tick();
    expect_out("rd64w.c1", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    // rd=4: high half lands in x5
    issue(WB_SRC_PCPI, 5'd4);
    #1;
    expect_out("rd64.c0", 1'b1, 1'b1, 5'd4, 32'h0000_0001, 1'b0);
    tick();
    expect_out("rd64.c1", 1'b0, 1'b1, 5'd5, 32'h0000_0002, 1'b0);
    tick();
    // Reset in RD64_HI
    #1;
    expect_out("rd64r.c0", 1'b1, 1'b1, 5'd4, 32'h0000_0001, 1'b0);
    tick();
    rst_ni = 1'b0;
    #1;
    check("rd64r.stall", {31'd0, bus.stall_WB_o}, 32'd0);
    check("rd64r.we",    {31'd0, bus.rf_we_o},    32'd0);
    check("rd64r.wdata", bus.rf_wdata_o,          32'd0);
    tick();
    rst_ni = 1'b1;
    quiet();
    #1;
    expect_out("rd64r.idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
`else
    expect_out("rd64off", 1'b0, 1'b1, 5'd31, 32'h0000_0001, 1'b0);
    tick();
    quiet();
`endif

    // Reset in MEM_WAIT drops the pending load
    issue(WB_SRC_MEM, 5'd8);
    #1;
    expect_out("mwr.w0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    rst_ni = 1'b0;
    #1;
    check("mwr.stall", {31'd0, bus.stall_WB_o}, 32'd0);
    check("mwr.waddr", {27'd0, bus.rf_waddr_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    quiet();
    #1;
    expect_out("mwr.idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(WB_SRC_ALU, 5'd6);
    bus.alu_out_i = 32'h0000_0666;
    #1;
    expect_out("mwr.alu", 1'b0, 1'b1, 5'd6, 32'h0000_0666, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
